// File: rtl/corefifo_wr_ptr_gray_enc_pkg.sv
// Shared constants and helpers for the CoreFIFO write-side pointer logic.
// Widths here describe the default geometry; modules derive their own from ADDRWIDTH.
package corefifo_wr_ptr_gray_enc_pkg;

    localparam int unsigned CF_ADDRWIDTH = 3;
    localparam int unsigned PTRW         = CF_ADDRWIDTH + 1;
    localparam int unsigned DEPTH        = 1 << CF_ADDRWIDTH;

    // A Gray pointer exactly DEPTH ahead of another differs only in its two MSBs.
    function automatic logic [31:0] full_cmp_gray(input logic [31:0] g, input int unsigned ptrw);
        return g ^ (32'h3 << (ptrw - 2));
    endfunction

endpackage

// File: rtl/corefifo_binToGrayConv.sv
// Combinational binary-to-Gray converter.
module corefifo_binToGrayConv #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/corefifo_wr_ptr_gray_enc.sv
// Write-domain pointer engine: binary write pointer, registered Gray pointer for the
// read-domain synchronizer, and full/afull/level/overflow from the synced read pointer.
module corefifo_wr_ptr_gray_enc
    import corefifo_wr_ptr_gray_enc_pkg::*;
#(
    parameter int unsigned ADDRWIDTH    = CF_ADDRWIDTH,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH:0]   rd_gray_sync,
    output logic                 wr_we,
    output logic [ADDRWIDTH-1:0] wr_addr,
    output logic [ADDRWIDTH:0]   wr_gray,
    output logic                 full,
    output logic                 afull,
    output logic [ADDRWIDTH:0]   wr_count,
    output logic                 overflow
);

    localparam int unsigned PtrW = ADDRWIDTH + 1;

    logic [PtrW-1:0] wbin_q, wbin_d;
    logic [PtrW-1:0] wr_gray_q, wr_gray_d;
    logic [PtrW-1:0] wr_count_q, wr_count_d;
    logic            full_q, full_d;
    logic            afull_q, afull_d;
    logic            overflow_q, overflow_d;

    logic [PtrW-1:0] gray_next;
    logic [PtrW-1:0] rd_bin;

    always_comb begin
        wr_we  = wr_en & ~full_q & ~reset;
        wbin_d = wbin_q + PtrW'(wr_we);
    end

    corefifo_binToGrayConv #(
        .WIDTH (PtrW)
    ) u_bin2gray (
        .bin  (wbin_d),
        .gray (gray_next)
    );

    // Gray-to-binary, MSB down: each bit is the XOR of all Gray bits above and including it.
    always_comb begin
        rd_bin = rd_gray_sync;
        for (int i = int'(PtrW) - 2; i >= 0; i--) begin
            rd_bin[i] = rd_bin[i+1] ^ rd_gray_sync[i];
        end
    end

    always_comb begin
        wr_gray_d  = gray_next;
        wr_count_d = wbin_d - rd_bin;
        full_d     = (32'(gray_next) == full_cmp_gray(32'(rd_gray_sync), PtrW));
        afull_d    = (32'(wr_count_d) >= AFULL_THRESH);
        overflow_d = wr_en & full_q & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbin_q     <= '0;
            wr_gray_q  <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wr_gray_q  <= wr_gray_d;
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_addr  = wbin_q[ADDRWIDTH-1:0];
    assign wr_gray  = wr_gray_q;
    assign wr_count = wr_count_q;
    assign full     = full_q;
    assign afull    = afull_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_corefifo_wr_ptr_gray_enc.sv
// Scoreboard bench for corefifo_wr_ptr_gray_enc (ADDRWIDTH=3, AFULL_THRESH=6).
module tb_corefifo_wr_ptr_gray_enc;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] rd_gray_sync;
    logic       wr_we;
    logic [2:0] wr_addr;
    logic [3:0] wr_gray;
    logic       full;
    logic       afull;
    logic [3:0] wr_count;
    logic       overflow;

    corefifo_wr_ptr_gray_enc #(
        .ADDRWIDTH    (3),
        .AFULL_THRESH (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .rd_gray_sync (rd_gray_sync),
        .wr_we        (wr_we),
        .wr_addr      (wr_addr),
        .wr_gray      (wr_gray),
        .full         (full),
        .afull        (afull),
        .wr_count     (wr_count),
        .overflow     (overflow)
    );

    typedef struct {
        logic [3:0] gray;
        logic [2:0] addr;
        logic [3:0] cnt;
        logic       full;
        logic       afull;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_wbin = '0;
    logic       m_full = 1'b0;

    logic       mon_valid = 1'b0;
    logic [3:0] mon_prev  = '0;
    logic       mon_burst = 1'b0;
    int         wraps     = 0;
    int         full_hits = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check comb outputs, predict, clock, compare.
    task automatic step(input logic en, input logic [3:0] rd);
        exp_t       e;
        logic       we;
        logic [3:0] nb;
        logic [3:0] cnt;
        wr_en        = en;
        rd_gray_sync = rd ^ (rd >> 1);
        #1;
        we = en & ~m_full;
        check("wr_we", 32'(wr_we), 32'(we));
        check("wr_addr_pre", 32'(wr_addr), 32'(m_wbin[2:0]));
        nb      = m_wbin + 4'(we);
        cnt     = nb - rd;
        e.gray  = nb ^ (nb >> 1);
        e.addr  = nb[2:0];
        e.cnt   = cnt;
        e.full  = (cnt == 4'd8);
        e.afull = (cnt >= 4'd6);
        e.ovf   = en & m_full;
        sb.push_back(e);
        m_wbin = nb;
        m_full = e.full;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("wr_gray", 32'(wr_gray), 32'(e.gray));
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_count", 32'(wr_count), 32'(e.cnt));
            check("full", 32'(full), 32'(e.full));
            check("afull", 32'(afull), 32'(e.afull));
            check("overflow", 32'(overflow), 32'(e.ovf));
        end
        wr_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gray"}, 32'(wr_gray), 32'd0);
        check({tag, "_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_count"}, 32'(wr_count), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_afull"}, 32'(afull), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_we"}, 32'(wr_we), 32'd0);
    endtask

    // Gray one-bit-step and full/level agreement, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            mon_valid <= 1'b0;
        end else begin
            check("full_vs_count", 32'(full), 32'(wr_count == 4'd8));
            if (mon_valid && wr_gray != mon_prev)
                check("gray_onebit", 32'($countones(wr_gray ^ mon_prev)), 32'd1);
            if (mon_burst && mon_valid && mon_prev == 4'h8 && wr_gray == 4'h0)
                wraps <= wraps + 1;
            if (mon_burst && full)
                full_hits <= full_hits + 1;
            mon_prev  <= wr_gray;
            mon_valid <= 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] gtab [8];
        gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        reset        = 1'b1;
        wr_en        = 1'b1;
        rd_gray_sync = '0;
        #2;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        #1;

        // 1: fill from empty
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'd0);
            check("t1_gray_tab", 32'(wr_gray), 32'(gtab[i]));
        end
        check("t1_full", 32'(full), 32'd1);

        // 2: writes while full are dropped and flagged
        step(1'b1, 4'd0);
        step(1'b1, 4'd0);
        step(1'b0, 4'd0);
        check("t2_gray_held", 32'(wr_gray), 32'hC);

        // 3: reader frees one slot, next write refills
        step(1'b0, 4'd1);
        step(1'b1, 4'd1);

        // 4: simultaneous write and read
        step(1'b0, 4'd2);
        step(1'b1, 4'd3);
        check("t4_count", 32'(wr_count), 32'd7);

        // 5: long burst with reader two behind, across pointer wraps
        step(1'b0, m_wbin - 4'd2);
        mon_burst = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1, m_wbin - 4'd2);
        @(negedge clk);
        mon_burst = 1'b0;
        check("t5_wraps", 32'(wraps), 32'd3);
        check("t5_full_never", 32'(full_hits), 32'd0);
        @(posedge clk);
        #1;

        // 6: async reset between edges mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, m_wbin);
        wr_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_zero("t6_async");
        @(posedge clk);
        #1;
        check_zero("t6_held");
        #2;
        reset  = 1'b0;
        wr_en  = 1'b0;
        m_wbin = '0;
        m_full = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 4'd0);
        check("t6_resume_addr", 32'(wr_addr), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
